// File: rtl/line_fetch_arbiter.sv
// Arbitrates one single-port framebuffer between per-line display prefetch (priority) and draw writes.
// Fetch request issues the cycle after the line strobe; line-buffer writes trail mem_ack by one cycle.
module line_fetch_arbiter #(
  parameter int CORDW      = 16,
  parameter int V_RES      = 720,
  parameter int LINE_WORDS = 80,
  parameter int ADDRW      = 20,
  parameter int DATAW      = 16,
  parameter int BASE       = 0,
  parameter int LBAW       = 7
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             line,
  input  logic             frame,
  input  logic [CORDW-1:0] sy,
  input  logic             drw_req,
  input  logic [ADDRW-1:0] drw_addr,
  input  logic [DATAW-1:0] drw_data,
  output logic             drw_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             lb_we,
  output logic [LBAW-1:0]  lb_addr,
  output logic [DATAW-1:0] lb_data,
  output logic             busy,
  output logic             underrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DISP = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;

  logic [1:0]       state;
  logic             pend;
  logic             abort;
  logic [CORDW-1:0] row;
  logic [LBAW-1:0]  word;
  logic [1:0]       rst_sync;
  logic             rst_n;

  logic             trig;
  logic             last;
  logic [CORDW-1:0] row_src;
  logic [ADDRW-1:0] start_addr;
  logic [ADDRW-1:0] next_addr;

  // Assertion is immediate; deassertion is retimed onto clk_pix.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  function automatic logic [ADDRW-1:0] row_base(input logic [CORDW-1:0] r);
    return ADDRW'(BASE) + ADDRW'(r) * ADDRW'(LINE_WORDS);
  endfunction

  // sy is signed: a set MSB means a negative (blanking) row.
  assign trig       = line & ~sy[CORDW-1] & (sy < CORDW'(V_RES));
  assign last       = (word == LBAW'(LINE_WORDS - 1));
  assign row_src    = trig ? sy : row;
  assign start_addr = row_base(row_src);
  assign next_addr  = row_base(row) + ADDRW'(word);

  assign busy    = pend | (state == DISP);
  assign drw_ack = (state == DRAW) & mem_req & mem_ack;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      abort     <= 1'b0;
      row       <= '0;
      word      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lb_we     <= 1'b0;
      lb_addr   <= '0;
      lb_data   <= '0;
      underrun  <= 1'b0;
    end else begin
      lb_we <= 1'b0;
      if (trig) begin
        row  <= sy;
        pend <= 1'b1;
      end
      if (trig && busy) underrun <= 1'b1;
      else if (frame)   underrun <= 1'b0;

      case (state)
        IDLE: begin
          if (trig || pend) begin
            state    <= DISP;
            pend     <= 1'b0;
            word     <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= start_addr;
          end else if (drw_req) begin
            state     <= DRAW;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= drw_addr;
            mem_wdata <= drw_data;
          end
        end
        DISP: begin
          if (mem_req) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              // A superseded row's in-flight word is read but never lands in the line buffer.
              if (!(abort || trig)) begin
                lb_we   <= 1'b1;
                lb_addr <= word;
                lb_data <= mem_rdata;
              end
              if (abort || trig || last) begin
                state <= IDLE;
                abort <= 1'b0;
              end else begin
                word <= word + LBAW'(1);
              end
            end else if (trig) begin
              abort <= 1'b1;
            end
          end else if (trig) begin
            state <= IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= next_addr;
          end
        end
        DRAW: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Directed bench for line_fetch_arbiter: a wait-state memory responder plus a negedge event logger.
module tb_line_fetch_arbiter;
  localparam int CORDW = 16;
  localparam int ADDRW = 20;
  localparam int DATAW = 16;
  localparam int LBAW  = 7;

  logic             clk_pix = 1'b0;
  logic             rst_pix_n = 1'b0;
  logic             line = 1'b0;
  logic             frame = 1'b0;
  logic [CORDW-1:0] sy = '0;
  logic             drw_req = 1'b0;
  logic [ADDRW-1:0] drw_addr = '0;
  logic [DATAW-1:0] drw_data = '0;
  logic             drw_ack;
  logic             mem_req;
  logic             mem_we;
  logic [ADDRW-1:0] mem_addr;
  logic [DATAW-1:0] mem_wdata;
  logic             mem_ack = 1'b0;
  logic [DATAW-1:0] mem_rdata = '0;
  logic             lb_we;
  logic [LBAW-1:0]  lb_addr;
  logic [DATAW-1:0] lb_data;
  logic             busy;
  logic             underrun;

  always #5 clk_pix = ~clk_pix;

  line_fetch_arbiter #(.LINE_WORDS(4), .BASE('h100)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .line(line), .frame(frame), .sy(sy),
    .drw_req(drw_req), .drw_addr(drw_addr), .drw_data(drw_data), .drw_ack(drw_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_data(lb_data), .busy(busy), .underrun(underrun)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wait_cyc = 0;
  int wcnt = 0;
  int req_cnt = 0;
  int lbwe_cnt = 0;
  int busy_cnt = 0;
  logic [ADDRW-1:0] rd_q[$];
  int               rd_cyc[$];
  logic [LBAW-1:0]  lba_q[$];
  logic [DATAW-1:0] lbd_q[$];
  int               lb_cyc[$];
  int               drw_cyc[$];

  function automatic logic [DATAW-1:0] rd_of(input logic [ADDRW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Memory model: acks after wait_cyc idle cycles, read data derived from the address.
  initial begin
    forever begin
      @(posedge clk_pix);
      cyc++;
      #1;
      if (mem_req) begin
        if (wcnt == wait_cyc) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_of(mem_addr);
          wcnt      = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_pix);
      if (mem_req && mem_ack && !mem_we) begin
        rd_q.push_back(mem_addr);
        rd_cyc.push_back(cyc);
      end
      if (lb_we) begin
        lba_q.push_back(lb_addr);
        lbd_q.push_back(lb_data);
        lb_cyc.push_back(cyc);
      end
      if (drw_ack) drw_cyc.push_back(cyc);
      if (mem_req) req_cnt++;
      if (lb_we) lbwe_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic step();
    @(negedge clk_pix);
    #1;
  endtask

  task automatic clear();
    @(posedge clk_pix);
    #2;
    rd_q.delete(); rd_cyc.delete(); lba_q.delete(); lbd_q.delete(); lb_cyc.delete();
    drw_cyc.delete();
    req_cnt = 0; lbwe_cnt = 0; busy_cnt = 0;
  endtask

  task automatic pulse_line(input logic [CORDW-1:0] v);
    @(posedge clk_pix);
    #1;
    line = 1'b1;
    sy   = v;
    @(posedge clk_pix);
    #1;
    line = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit, output int fall);
    logic ok;
    ok   = 1'b0;
    fall = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (!busy) begin
        ok   = 1'b1;
        fall = cyc;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int   fall;
    int   t0;
    logic ok;

    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_lb_we", 32'(lb_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_drw_ack", 32'(drw_ack), 32'd0);
    repeat (3) @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;
    repeat (4) @(posedge clk_pix);

    // 1: row 5 fetch, zero-wait memory
    wait_cyc = 0;
    clear();
    pulse_line(16'd5);
    step();
    check("t1_first_req", 32'(mem_req), 32'd1);
    check("t1_first_addr", 32'(mem_addr), 32'h114);
    check("t1_first_we", 32'(mem_we), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1_timeout", 60, fall);
    check("t1_nreads", 32'(rd_q.size()), 32'd4);
    check("t1_nlb", 32'(lba_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_q.size()) check("t1_rd_addr", 32'(rd_q[i]), 32'h114 + 32'(i));
      if (i < lba_q.size()) begin
        check("t1_lb_addr", 32'(lba_q[i]), 32'(i));
        check("t1_lb_data", 32'(lbd_q[i]), 32'(rd_of(20'h114 + 20'(i))));
      end
    end
    if (rd_cyc.size() == 4) check("t1_busy_fall", 32'(fall - rd_cyc[3]), 32'd1);

    // 2: lone draw write, three wait cycles
    wait_cyc = 3;
    clear();
    @(posedge clk_pix);
    #1;
    drw_req  = 1'b1;
    drw_addr = 20'h2A;
    drw_data = 16'hBEEF;
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (drw_ack) begin
        ok = 1'b1;
        check("t2_we", 32'(mem_we), 32'd1);
        check("t2_addr", 32'(mem_addr), 32'h2A);
        check("t2_wdata", 32'(mem_wdata), 32'hBEEF);
        check("t2_ack_coincide", 32'(mem_ack), 32'd1);
        check("t2_latency", 32'(cyc - t0), 32'd4);
        break;
      end
    end
    check("t2_timeout", 32'(ok), 32'd1);
    @(posedge clk_pix);
    #1;
    drw_req = 1'b0;
    repeat (6) step();
    check("t2_one_ack", 32'(drw_cyc.size()), 32'd1);
    check("t2_no_reads", 32'(rd_q.size()), 32'd0);

    // 3: simultaneous line(sy=0) and draw request
    wait_cyc = 0;
    clear();
    @(posedge clk_pix);
    #1;
    line     = 1'b1;
    sy       = 16'd0;
    drw_req  = 1'b1;
    drw_addr = 20'h33;
    drw_data = 16'h1234;
    @(posedge clk_pix);
    #1;
    line = 1'b0;
    step();
    check("t3_disp_wins_we", 32'(mem_we), 32'd0);
    check("t3_disp_wins_addr", 32'(mem_addr), 32'h100);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (drw_ack) begin
        ok = 1'b1;
        check("t3_draw_addr", 32'(mem_addr), 32'h33);
        break;
      end
    end
    check("t3_timeout", 32'(ok), 32'd1);
    @(posedge clk_pix);
    #1;
    drw_req = 1'b0;
    check("t3_nreads", 32'(rd_q.size()), 32'd4);
    check("t3_nlb", 32'(lb_cyc.size()), 32'd4);
    if (rd_q.size() == 4) check("t3_last_read", 32'(rd_q[3]), 32'h103);
    if (lb_cyc.size() == 4 && drw_cyc.size() >= 1)
      check("t3_draw_after_lb", 32'(drw_cyc[0] > lb_cyc[3]), 32'd1);

    // 4: overrun during word 2 of row 5
    wait_cyc = 2;
    clear();
    pulse_line(16'd5);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req && mem_addr == 20'h116) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_reach_word2", 32'(ok), 32'd1);
    pulse_line(16'd6);
    step();
    check("t4_underrun_set", 32'(underrun), 32'd1);
    wait_idle("t4_timeout", 80, fall);
    check("t4_nreads", 32'(rd_q.size()), 32'd7);
    if (rd_q.size() == 7) begin
      check("t4_word2_read", 32'(rd_q[2]), 32'h116);
      check("t4_next_read", 32'(rd_q[3]), 32'h118);
      check("t4_final_read", 32'(rd_q[6]), 32'h11B);
    end
    check("t4_nlb", 32'(lba_q.size()), 32'd6);
    if (lba_q.size() == 6) begin
      check("t4_lb1_addr", 32'(lba_q[1]), 32'd1);
      check("t4_lb2_addr", 32'(lba_q[2]), 32'd0);
      check("t4_lb2_data", 32'(lbd_q[2]), 32'(rd_of(20'h118)));
      check("t4_lb5_addr", 32'(lba_q[5]), 32'd3);
      check("t4_lb5_data", 32'(lbd_q[5]), 32'(rd_of(20'h11B)));
    end
    check("t4_underrun_sticky", 32'(underrun), 32'd1);
    @(posedge clk_pix);
    #1;
    frame = 1'b1;
    @(posedge clk_pix);
    #1;
    frame = 1'b0;
    step();
    check("t4_underrun_clear", 32'(underrun), 32'd0);

    // 5: out-of-range rows are ignored
    wait_cyc = 0;
    clear();
    pulse_line(16'hFFFD);
    repeat (5) step();
    pulse_line(16'd720);
    repeat (5) step();
    check("t5_no_req", 32'(req_cnt), 32'd0);
    check("t5_no_busy", 32'(busy_cnt), 32'd0);
    check("t5_no_underrun", 32'(underrun), 32'd0);

    // 6: reset mid-fetch
    wait_cyc = 1;
    clear();
    pulse_line(16'd2);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (lb_we) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_mid_fetch", 32'(ok), 32'd1);
    rst_pix_n = 1'b0;
    #1;
    check("t6_rst_mem_req", 32'(mem_req), 32'd0);
    check("t6_rst_lb_we", 32'(lb_we), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;
    clear();
    repeat (20) step();
    check("t6_no_req_after", 32'(req_cnt), 32'd0);
    check("t6_no_lb_after", 32'(lbwe_cnt), 32'd0);
    pulse_line(16'd1);
    step();
    check("t6_refetch_req", 32'(mem_req), 32'd1);
    check("t6_refetch_addr", 32'(mem_addr), 32'h104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
